axil_master_queued: RTL and testbench

Parametrised AXI4-Lite master. Write and read commands enter per-direction command FIFOs through valid/ready interfaces. Each transaction carries its own byte strobe. Each response returns through a registered valid/ready response slot. A per-direction timeout recovers from a dead slave. Sits between register-sequencing logic (DMA setup, config engines) and the AXI interconnect.

---
 rtl/axil_master_pkg.sv | 20 ++
 rtl/axil_cmd_fifo.sv | 62 ++++++
 rtl/axil_master_queued.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_axil_master_queued.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_master_pkg.sv
// Shared response codes, FSM states and sizing helper for the queued AXI4-Lite master.
package axil_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } axil_state_e;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous command FIFO with a registered head; a push into an empty FIFO
// becomes visible at the output one cycle later. Capacity counts the head register.
module axil_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_mcnt;
  logic             r_ovld;
  logic [WIDTH-1:0] r_dout;
  logic             w_push;
  logic             w_pop;
  logic             w_load;

  assign o_full  = (r_mcnt + (PW+1)'(r_ovld)) == (PW+1)'(DEPTH);
  assign o_empty = ~r_ovld;
  assign o_dout  = r_dout;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & r_ovld;
  // Refill the head register whenever it is free or being taken this cycle.
  assign w_load = (r_mcnt != '0) & (~r_ovld | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mcnt <= '0;
      r_ovld <= 1'b0;
      r_dout <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_load) r_rptr <= r_rptr + PW'(1);
      r_mcnt <= r_mcnt + (PW+1)'(w_push) - (PW+1)'(w_load);
      if (w_load) begin
        r_dout <= r_mem[r_rptr];
        r_ovld <= 1'b1;
      end else if (w_pop) begin
        r_ovld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_master_queued.sv
// AXI4-Lite master with per-direction command FIFOs, one outstanding transaction
// per direction, registered response slots and a dead-slave timeout.
module axil_master_queued
  import axil_master_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   wcmd_addr,
  input  logic [DW-1:0]   wcmd_data,
  input  logic [DW/8-1:0] wcmd_strb,
  input  logic            wcmd_valid,
  output logic            wcmd_ready,
  output logic [1:0]      wrsp_resp,
  output logic            wrsp_timeout,
  output logic            wrsp_valid,
  input  logic            wrsp_ready,
  input  logic [AW-1:0]   rcmd_addr,
  input  logic            rcmd_valid,
  output logic            rcmd_ready,
  output logic [DW-1:0]   rrsp_data,
  output logic [1:0]      rrsp_resp,
  output logic            rrsp_timeout,
  output logic            rrsp_valid,
  input  logic            rrsp_ready,
  output logic            idle,
  output logic [AW-1:0]   AXI_AWADDR,
  output logic            AXI_AWVALID,
  input  logic            AXI_AWREADY,
  output logic [DW-1:0]   AXI_WDATA,
  output logic [DW/8-1:0] AXI_WSTRB,
  output logic            AXI_WVALID,
  input  logic            AXI_WREADY,
  input  logic [1:0]      AXI_BRESP,
  input  logic            AXI_BVALID,
  output logic            AXI_BREADY,
  output logic [AW-1:0]   AXI_ARADDR,
  output logic            AXI_ARVALID,
  input  logic            AXI_ARREADY,
  input  logic [DW-1:0]   AXI_RDATA,
  input  logic [1:0]      AXI_RRESP,
  input  logic            AXI_RVALID,
  output logic            AXI_RREADY
);

  localparam int SW  = DW / 8;
  localparam int WFW = AW + DW + SW;
  localparam int CW  = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  // ---------------- write path ----------------
  logic            w_wfifo_full;
  logic            w_wfifo_empty;
  logic [WFW-1:0]  w_wfifo_dout;
  logic            w_wpop;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_b_hs;
  logic            w_waddr_done;
  logic            w_wexp;
  logic            w_wrsp_ok;
  logic            w_wrsp_to;
  axil_state_e     r_wst;
  axil_state_e     w_wst_nxt;
  logic [AW-1:0]   r_awaddr;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_bready;
  logic [CW-1:0]   r_wcnt;
  logic            r_wrsp_valid;
  logic [1:0]      r_wrsp_resp;
  logic            r_wrsp_timeout;

  axil_cmd_fifo #(.WIDTH(WFW), .DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (wcmd_valid),
    .i_din   ({wcmd_addr, wcmd_data, wcmd_strb}),
    .o_full  (w_wfifo_full),
    .i_pop   (w_wpop),
    .o_dout  (w_wfifo_dout),
    .o_empty (w_wfifo_empty)
  );

  assign wcmd_ready   = ~w_wfifo_full;
  assign w_aw_hs      = r_awvalid & AXI_AWREADY;
  assign w_w_hs       = r_wvalid & AXI_WREADY;
  assign w_b_hs       = r_bready & AXI_BVALID;
  assign w_waddr_done = (~r_awvalid | w_aw_hs) & (~r_wvalid | w_w_hs);
  assign w_wexp       = (TIMEOUT > 0) && (r_wst != IDLE) && (r_wcnt == TO_LAST);
  assign w_wpop       = (r_wst == IDLE) && !w_wfifo_empty && (!r_wrsp_valid || wrsp_ready);

  // A completing B handshake beats expiry; a stalled address phase does not.
  always_comb begin
    w_wst_nxt = r_wst;
    w_wrsp_ok = 1'b0;
    w_wrsp_to = 1'b0;
    case (r_wst)
      IDLE: if (w_wpop) w_wst_nxt = ADDR;
      ADDR: begin
        if (w_waddr_done && w_b_hs) begin
          w_wst_nxt = IDLE;
          w_wrsp_ok = 1'b1;
        end else if (w_wexp) begin
          w_wst_nxt = IDLE;
          w_wrsp_to = 1'b1;
        end else if (w_waddr_done) begin
          w_wst_nxt = RESP;
        end
      end
      RESP: begin
        if (w_b_hs) begin
          w_wst_nxt = IDLE;
          w_wrsp_ok = 1'b1;
        end else if (w_wexp) begin
          w_wst_nxt = IDLE;
          w_wrsp_to = 1'b1;
        end
      end
      default: w_wst_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_wst <= IDLE;
    else         r_wst <= w_wst_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_wcnt    <= '0;
    end else if (w_wpop) begin
      {r_awaddr, r_wdata, r_wstrb} <= w_wfifo_dout;
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_bready  <= 1'b1;
      r_wcnt    <= '0;
    end else begin
      if (w_aw_hs || w_wrsp_to)   r_awvalid <= 1'b0;
      if (w_w_hs || w_wrsp_to)    r_wvalid  <= 1'b0;
      if (w_wrsp_ok || w_wrsp_to) r_bready  <= 1'b0;
      if (r_wst != IDLE)          r_wcnt    <= r_wcnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrsp_valid   <= 1'b0;
      r_wrsp_resp    <= '0;
      r_wrsp_timeout <= 1'b0;
    end else if (w_wrsp_ok) begin
      r_wrsp_valid   <= 1'b1;
      r_wrsp_resp    <= AXI_BRESP;
      r_wrsp_timeout <= 1'b0;
    end else if (w_wrsp_to) begin
      r_wrsp_valid   <= 1'b1;
      r_wrsp_resp    <= RESP_DECERR;
      r_wrsp_timeout <= 1'b1;
    end else if (wrsp_ready) begin
      r_wrsp_valid   <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  logic            w_rfifo_full;
  logic            w_rfifo_empty;
  logic [AW-1:0]   w_rfifo_dout;
  logic            w_rpop;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic            w_rexp;
  logic            w_rrsp_ok;
  logic            w_rrsp_to;
  axil_state_e     r_rst;
  axil_state_e     w_rst_nxt;
  logic [AW-1:0]   r_araddr;
  logic            r_arvalid;
  logic            r_rready;
  logic [CW-1:0]   r_rcnt;
  logic            r_rrsp_valid;
  logic [DW-1:0]   r_rrsp_data;
  logic [1:0]      r_rrsp_resp;
  logic            r_rrsp_timeout;

  axil_cmd_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_rfifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (rcmd_valid),
    .i_din   (rcmd_addr),
    .o_full  (w_rfifo_full),
    .i_pop   (w_rpop),
    .o_dout  (w_rfifo_dout),
    .o_empty (w_rfifo_empty)
  );

  assign rcmd_ready = ~w_rfifo_full;
  assign w_ar_hs    = r_arvalid & AXI_ARREADY;
  assign w_r_hs     = r_rready & AXI_RVALID;
  assign w_rexp     = (TIMEOUT > 0) && (r_rst != IDLE) && (r_rcnt == TO_LAST);
  assign w_rpop     = (r_rst == IDLE) && !w_rfifo_empty && (!r_rrsp_valid || rrsp_ready);

  // R data may arrive with or ahead of the AR handshake and ends the transaction.
  always_comb begin
    w_rst_nxt = r_rst;
    w_rrsp_ok = 1'b0;
    w_rrsp_to = 1'b0;
    case (r_rst)
      IDLE: if (w_rpop) w_rst_nxt = ADDR;
      ADDR: begin
        if (w_r_hs) begin
          w_rst_nxt = IDLE;
          w_rrsp_ok = 1'b1;
        end else if (w_rexp) begin
          w_rst_nxt = IDLE;
          w_rrsp_to = 1'b1;
        end else if (w_ar_hs) begin
          w_rst_nxt = RESP;
        end
      end
      RESP: begin
        if (w_r_hs) begin
          w_rst_nxt = IDLE;
          w_rrsp_ok = 1'b1;
        end else if (w_rexp) begin
          w_rst_nxt = IDLE;
          w_rrsp_to = 1'b1;
        end
      end
      default: w_rst_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst <= IDLE;
    else         r_rst <= w_rst_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rcnt    <= '0;
    end else if (w_rpop) begin
      r_araddr  <= w_rfifo_dout;
      r_arvalid <= 1'b1;
      r_rready  <= 1'b1;
      r_rcnt    <= '0;
    end else begin
      if (w_ar_hs || w_rrsp_ok || w_rrsp_to) r_arvalid <= 1'b0;
      if (w_rrsp_ok || w_rrsp_to)            r_rready  <= 1'b0;
      if (r_rst != IDLE)                     r_rcnt    <= r_rcnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rrsp_valid   <= 1'b0;
      r_rrsp_data    <= '0;
      r_rrsp_resp    <= '0;
      r_rrsp_timeout <= 1'b0;
    end else if (w_rrsp_ok) begin
      r_rrsp_valid   <= 1'b1;
      r_rrsp_data    <= AXI_RDATA;
      r_rrsp_resp    <= AXI_RRESP;
      r_rrsp_timeout <= 1'b0;
    end else if (w_rrsp_to) begin
      r_rrsp_valid   <= 1'b1;
      r_rrsp_data    <= '0;
      r_rrsp_resp    <= RESP_DECERR;
      r_rrsp_timeout <= 1'b1;
    end else if (rrsp_ready) begin
      r_rrsp_valid   <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign AXI_AWADDR   = r_awaddr;
  assign AXI_AWVALID  = r_awvalid;
  assign AXI_WDATA    = r_wdata;
  assign AXI_WSTRB    = r_wstrb;
  assign AXI_WVALID   = r_wvalid;
  assign AXI_BREADY   = r_bready;
  assign AXI_ARADDR   = r_araddr;
  assign AXI_ARVALID  = r_arvalid;
  assign AXI_RREADY   = r_rready;

  assign wrsp_valid   = r_wrsp_valid;
  assign wrsp_resp    = r_wrsp_resp;
  assign wrsp_timeout = r_wrsp_timeout;
  assign rrsp_valid   = r_rrsp_valid;
  assign rrsp_data    = r_rrsp_data;
  assign rrsp_resp    = r_rrsp_resp;
  assign rrsp_timeout = r_rrsp_timeout;

  assign idle = w_wfifo_empty & w_rfifo_empty & (r_wst == IDLE) & (r_rst == IDLE)
              & ~r_wrsp_valid & ~r_rrsp_valid;

endmodule

// File: tb/tb_axil_master_queued.sv
// Directed bench for axil_master_queued: the bus slave is driven step by step
// from one initial block, outputs are sampled 1 time unit after each rising edge.
module tb_axil_master_queued;

  logic        clk;
  logic        resetn;
  logic [31:0] wcmd_addr, wcmd_data;
  logic [3:0]  wcmd_strb;
  logic        wcmd_valid, wcmd_ready;
  logic [1:0]  wrsp_resp;
  logic        wrsp_timeout, wrsp_valid, wrsp_ready;
  logic [31:0] rcmd_addr;
  logic        rcmd_valid, rcmd_ready;
  logic [31:0] rrsp_data;
  logic [1:0]  rrsp_resp;
  logic        rrsp_timeout, rrsp_valid, rrsp_ready;
  logic        idle;
  logic [31:0] AXI_AWADDR;
  logic        AXI_AWVALID, AXI_AWREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID, AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID, AXI_BREADY;
  logic [31:0] AXI_ARADDR;
  logic        AXI_ARVALID, AXI_ARREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID, AXI_RREADY;

  int n_checks = 0;
  int n_fail   = 0;
  int b_cnt    = 0;
  bit r_auto   = 1'b0;

  axil_master_queued #(.DW(32), .AW(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .wcmd_addr(wcmd_addr), .wcmd_data(wcmd_data), .wcmd_strb(wcmd_strb),
    .wcmd_valid(wcmd_valid), .wcmd_ready(wcmd_ready),
    .wrsp_resp(wrsp_resp), .wrsp_timeout(wrsp_timeout),
    .wrsp_valid(wrsp_valid), .wrsp_ready(wrsp_ready),
    .rcmd_addr(rcmd_addr), .rcmd_valid(rcmd_valid), .rcmd_ready(rcmd_ready),
    .rrsp_data(rrsp_data), .rrsp_resp(rrsp_resp), .rrsp_timeout(rrsp_timeout),
    .rrsp_valid(rrsp_valid), .rrsp_ready(rrsp_ready),
    .idle(idle),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
    .AXI_RREADY(AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (AXI_BVALID && AXI_BREADY) b_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // When r_auto is set the read slave returns data derived from the current ARADDR.
  task automatic tick();
    @(posedge clk);
    #1;
    if (r_auto) AXI_RDATA = 32'hC0DE_0000 + AXI_ARADDR;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench stalled");
  end

  initial begin
    logic [31:0] got [6];
    int n_rsp, n, rsp_seen, b_before;
    bit acc;

    resetn = 1'b0;
    wcmd_addr = '0; wcmd_data = '0; wcmd_strb = '0; wcmd_valid = 1'b0; wrsp_ready = 1'b0;
    rcmd_addr = '0; rcmd_valid = 1'b0; rrsp_ready = 1'b0;
    AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_BRESP = '0; AXI_BVALID = 1'b0;
    AXI_ARREADY = 1'b0; AXI_RDATA = '0; AXI_RRESP = '0; AXI_RVALID = 1'b0;
    #2;
    chk("rst_awvalid", AXI_AWVALID, 0);
    chk("rst_wvalid", AXI_WVALID, 0);
    chk("rst_bready", AXI_BREADY, 0);
    chk("rst_arvalid", AXI_ARVALID, 0);
    chk("rst_rready", AXI_RREADY, 0);
    chk("rst_awaddr", AXI_AWADDR, 0);
    chk("rst_wstrb", AXI_WSTRB, 0);
    chk("rst_rsp_valids", {wrsp_valid, rrsp_valid}, 0);
    chk("rst_idle", idle, 1);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // 1: single write, AW and W accepted together
    wcmd_addr = 32'h10; wcmd_data = 32'hDEADBEEF; wcmd_strb = 4'hF; wcmd_valid = 1'b1;
    chk("t1_wcmd_ready", wcmd_ready, 1);
    tick();
    wcmd_valid = 1'b0;
    chk("t1_aw_k", AXI_AWVALID, 0);
    tick();
    chk("t1_aw_k1", AXI_AWVALID, 0);
    tick();
    chk("t1_aw_k2", AXI_AWVALID, 1);
    chk("t1_awaddr", AXI_AWADDR, 32'h10);
    chk("t1_wdata", AXI_WDATA, 32'hDEADBEEF);
    chk("t1_wstrb", AXI_WSTRB, 4'hF);
    chk("t1_bready", AXI_BREADY, 1);
    chk("t1_busy", idle, 0);
    AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1;
    tick();
    AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0;
    chk("t1_valids_drop", {AXI_AWVALID, AXI_WVALID, AXI_BREADY}, 3'b001);
    AXI_BVALID = 1'b1; AXI_BRESP = 2'b00;
    tick();
    AXI_BVALID = 1'b0;
    chk("t1_wrsp_valid", wrsp_valid, 1);
    chk("t1_wrsp_resp", wrsp_resp, 2'b00);
    chk("t1_wrsp_to", wrsp_timeout, 0);
    chk("t1_bready_off", AXI_BREADY, 0);
    wrsp_ready = 1'b1;
    tick();
    wrsp_ready = 1'b0;
    chk("t1_idle_back", idle, 1);

    // 2: W accepted three cycles ahead of AW, strobe 0x3
    wcmd_addr = 32'h20; wcmd_data = 32'h12345678; wcmd_strb = 4'h3; wcmd_valid = 1'b1;
    tick();
    wcmd_valid = 1'b0;
    tick(); tick();
    chk("t2_aw_up", AXI_AWVALID, 1);
    chk("t2_wstrb", AXI_WSTRB, 4'h3);
    b_before = b_cnt;
    AXI_WREADY = 1'b1;
    tick();
    AXI_WREADY = 1'b0;
    chk("t2_w_drop", {AXI_AWVALID, AXI_WVALID}, 2'b10);
    tick(); tick();
    chk("t2_aw_hold", AXI_AWVALID, 1);
    AXI_AWREADY = 1'b1;
    tick();
    AXI_AWREADY = 1'b0;
    chk("t2_aw_drop", AXI_AWVALID, 0);
    AXI_BVALID = 1'b1; AXI_BRESP = 2'b01;
    tick(); tick();
    AXI_BVALID = 1'b0;
    chk("t2_one_b", b_cnt - b_before, 1);
    chk("t2_wrsp", {wrsp_valid, wrsp_resp, wrsp_timeout}, 4'b1010);
    wrsp_ready = 1'b1;
    tick();
    wrsp_ready = 1'b0;

    // 3: six reads against a depth-4 FIFO with the response slot stalled
    AXI_ARREADY = 1'b1; AXI_RVALID = 1'b1; AXI_RRESP = 2'b00; r_auto = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rcmd_addr = 32'(i); rcmd_valid = 1'b1;
      if (i == 4) chk("t3_ready_5th", rcmd_ready, 1);
      tick();
    end
    rcmd_addr = 32'd5;
    chk("t3_ready_6th", rcmd_ready, 0);
    tick(); tick();
    chk("t3_ready_held", rcmd_ready, 0);
    rrsp_ready = 1'b1;
    n_rsp = 0; acc = 1'b0;
    for (int c = 0; c < 100 && n_rsp < 6; c++) begin
      if (rrsp_valid) begin
        got[n_rsp] = rrsp_data;
        n_rsp++;
      end
      if (rcmd_valid && rcmd_ready) acc = 1'b1;
      tick();
      if (acc) rcmd_valid = 1'b0;
    end
    chk("t3_rsp_count", n_rsp, 6);
    chk("t3_6th_accepted", acc, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_data%0d", i), got[i], 32'hC0DE_0000 + i);
    r_auto = 1'b0; AXI_RVALID = 1'b0; AXI_ARREADY = 1'b0; rrsp_ready = 1'b0;
    tick();
    chk("t3_idle", idle, 1);

    // 4: AR never accepted -> timeout after 16 cycles, then the next read issues
    rcmd_addr = 32'h40; rcmd_valid = 1'b1;
    tick();
    rcmd_addr = 32'h44;
    tick();
    rcmd_valid = 1'b0;
    for (int c = 0; c < 10 && !AXI_ARVALID; c++) tick();
    chk("t4_ar_up", AXI_ARVALID, 1);
    chk("t4_araddr", AXI_ARADDR, 32'h40);
    n = 0;
    while (AXI_ARVALID && n < 100) begin
      tick();
      n++;
    end
    chk("t4_hold_cycles", n, 16);
    chk("t4_rrsp", {rrsp_valid, rrsp_resp, rrsp_timeout}, 4'b1111);
    chk("t4_rdata_zero", rrsp_data, 0);
    chk("t4_rready_off", AXI_RREADY, 0);
    rrsp_ready = 1'b1;
    tick();
    rrsp_ready = 1'b0;
    chk("t4_next_ar", AXI_ARVALID, 1);
    chk("t4_next_addr", AXI_ARADDR, 32'h44);
    AXI_ARREADY = 1'b1; AXI_RVALID = 1'b1; AXI_RDATA = 32'h5555AAAA; AXI_RRESP = 2'b00;
    tick();
    AXI_ARREADY = 1'b0; AXI_RVALID = 1'b0;
    chk("t4_normal", {rrsp_valid, rrsp_resp, rrsp_timeout}, 4'b1000);
    chk("t4_normal_data", rrsp_data, 32'h5555AAAA);
    rrsp_ready = 1'b1;
    tick();
    rrsp_ready = 1'b0;

    // 5: asynchronous reset with a write in flight and two queued
    for (int i = 0; i < 3; i++) begin
      wcmd_addr = 32'h100 + 32'(i * 4); wcmd_data = 32'(i); wcmd_strb = 4'hF; wcmd_valid = 1'b1;
      tick();
    end
    wcmd_valid = 1'b0;
    chk("t5_aw_inflight", AXI_AWVALID, 1);
    #3 resetn = 1'b0;
    #1;
    chk("t5_async_valids", {AXI_AWVALID, AXI_WVALID, AXI_BREADY}, 0);
    chk("t5_async_idle", idle, 1);
    tick();
    resetn = 1'b1;
    rsp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (wrsp_valid) rsp_seen++;
      tick();
    end
    chk("t5_wcmd_ready", wcmd_ready, 1);
    chk("t5_idle", idle, 1);
    chk("t5_no_aw", AXI_AWVALID, 0);
    chk("t5_no_rsp", rsp_seen, 0);

    // 6: concurrent write and read
    wcmd_addr = 32'h80; wcmd_data = 32'h11112222; wcmd_strb = 4'hF; wcmd_valid = 1'b1;
    rcmd_addr = 32'h90; rcmd_valid = 1'b1;
    tick();
    wcmd_valid = 1'b0; rcmd_valid = 1'b0;
    tick(); tick();
    chk("t6_both_up", {AXI_AWVALID, AXI_WVALID, AXI_ARVALID}, 3'b111);
    AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1; AXI_ARREADY = 1'b1;
    tick();
    AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_ARREADY = 1'b0;
    AXI_RVALID = 1'b1; AXI_RRESP = 2'b10; AXI_RDATA = 32'hA5A5A5A5;
    tick();
    AXI_RVALID = 1'b0;
    chk("t6_rrsp", {rrsp_valid, rrsp_resp, rrsp_timeout}, 4'b1100);
    chk("t6_rdata", rrsp_data, 32'hA5A5A5A5);
    chk("t6_w_pending", {wrsp_valid, AXI_BREADY}, 2'b01);
    AXI_BVALID = 1'b1; AXI_BRESP = 2'b00;
    tick();
    AXI_BVALID = 1'b0;
    chk("t6_wrsp", {wrsp_valid, wrsp_resp, wrsp_timeout}, 4'b1000);
    chk("t6_rrsp_held", rrsp_valid, 1);
    wrsp_ready = 1'b1; rrsp_ready = 1'b1;
    tick();
    wrsp_ready = 1'b0; rrsp_ready = 1'b0;
    chk("t6_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
